// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment driver family.
// Segment vectors are ordered a..g with index 0 = a, active low.
package seg_pkg;

    localparam logic [0:6] SEG_OFF = 7'b1111111;

    localparam logic [0:6] GLYPH_0 = 7'b0000001;
    localparam logic [0:6] GLYPH_1 = 7'b1001111;
    localparam logic [0:6] GLYPH_2 = 7'b0010010;
    localparam logic [0:6] GLYPH_3 = 7'b0000110;
    localparam logic [0:6] GLYPH_4 = 7'b1001100;
    localparam logic [0:6] GLYPH_5 = 7'b0100100;
    localparam logic [0:6] GLYPH_6 = 7'b0100000;
    localparam logic [0:6] GLYPH_7 = 7'b0001111;
    localparam logic [0:6] GLYPH_8 = 7'b0000000;
    localparam logic [0:6] GLYPH_9 = 7'b0000100;
    localparam logic [0:6] GLYPH_A = 7'b0001000;
    localparam logic [0:6] GLYPH_B = 7'b1100000;
    localparam logic [0:6] GLYPH_C = 7'b0110001;
    localparam logic [0:6] GLYPH_D = 7'b1000010;
    localparam logic [0:6] GLYPH_E = 7'b0110000;
    localparam logic [0:6] GLYPH_F = 7'b0111000;

    // Counter widths never collapse to zero bits, even for a single digit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit params_legal(input int num_digits, input int scan_div,
                                        input int blink_frames, input int hex_mode);
        return (num_digits >= 1) && (num_digits <= 8) && (scan_div >= 2) &&
               (blink_frames >= 1) && ((hex_mode == 0) || (hex_mode == 1));
    endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational 4-bit code to active-low 7-segment glyph decoder.
// Codes 10..15 fall back to "0" unless hex glyphs are enabled.
module seg_glyph_decode
    import seg_pkg::*;
(
    input  logic [3:0] code,
    input  logic       hex_mode,
    output logic [0:6] seg
);

    always_comb begin
        seg = GLYPH_0;
        case (code)
            4'h0: seg = GLYPH_0;
            4'h1: seg = GLYPH_1;
            4'h2: seg = GLYPH_2;
            4'h3: seg = GLYPH_3;
            4'h4: seg = GLYPH_4;
            4'h5: seg = GLYPH_5;
            4'h6: seg = GLYPH_6;
            4'h7: seg = GLYPH_7;
            4'h8: seg = GLYPH_8;
            4'h9: seg = GLYPH_9;
            4'hA: seg = hex_mode ? GLYPH_A : GLYPH_0;
            4'hB: seg = hex_mode ? GLYPH_B : GLYPH_0;
            4'hC: seg = hex_mode ? GLYPH_C : GLYPH_0;
            4'hD: seg = hex_mode ? GLYPH_D : GLYPH_0;
            4'hE: seg = hex_mode ? GLYPH_E : GLYPH_0;
            default: seg = hex_mode ? GLYPH_F : GLYPH_0;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit 7-segment scanner with frame-coherent input latching,
// leading-zero suppression and per-digit blinking. All outputs are registered.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64,
    parameter int HEX_MODE     = 0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [4*NUM_DIGITS-1:0]             digits,
    input  logic                                en,
    input  logic                                blank_set,
    input  logic                                lz_suppress,
    input  logic [NUM_DIGITS-1:0]               blink_mask,
    input  logic [NUM_DIGITS-1:0]               dp,
    output logic [0:6]                          seg,
    output logic                                dp_n,
    output logic [NUM_DIGITS-1:0]               an_n,
    output logic [clog2_min1(NUM_DIGITS)-1:0]   scan_idx
);

    localparam int IDX_W = clog2_min1(NUM_DIGITS);
    localparam int PRE_W = clog2_min1(SCAN_DIV);
    localparam int FRM_W = clog2_min1(BLINK_FRAMES);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    if (!params_legal(NUM_DIGITS, SCAN_DIV, BLINK_FRAMES, HEX_MODE)) begin : g_bad_params
        $error("seg_scan_driver: illegal parameter combination");
    end

    logic [PRE_W-1:0]                 pre_q, pre_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [FRM_W-1:0]                 frm_q, frm_d;
    logic                             blink_phase_q, blink_phase_d;
    logic [NUM_DIGITS-1:0][3:0]       lat_digits_q, lat_digits_d;
    logic [NUM_DIGITS-1:0]            lat_blink_q, lat_blink_d;
    logic [NUM_DIGITS-1:0]            lat_dp_q, lat_dp_d;
    logic                             lat_lz_q, lat_lz_d;
    logic [0:6]                       seg_q, seg_d;
    logic                             dp_n_q, dp_n_d;
    logic [NUM_DIGITS-1:0]            an_n_q, an_n_d;
    logic [IDX_W-1:0]                 scan_idx_q, scan_idx_d;

    logic                             slot_end;
    logic                             frame_end;
    logic [NUM_DIGITS-1:0]            supp;
    logic                             zero_above;
    logic [0:6]                       glyph;

    assign slot_end  = (pre_q == PRE_LAST);
    assign frame_end = slot_end && (idx_q == IDX_LAST);

    seg_glyph_decode u_glyph (
        .code     (lat_digits_q[idx_q]),
        .hex_mode (HEX_MODE != 0),
        .seg      (glyph)
    );

    always_comb begin
        pre_d         = slot_end ? '0 : pre_q + PRE_W'(1);
        idx_d         = idx_q;
        frm_d         = frm_q;
        blink_phase_d = blink_phase_q;
        lat_digits_d  = lat_digits_q;
        lat_blink_d   = lat_blink_q;
        lat_dp_d      = lat_dp_q;
        lat_lz_d      = lat_lz_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        if (frame_end) begin
            lat_digits_d = digits;
            lat_blink_d  = blink_mask;
            lat_dp_d     = dp;
            lat_lz_d     = lz_suppress;
            if (frm_q == FRM_LAST) begin
                frm_d         = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frm_d = frm_q + FRM_W'(1);
            end
        end
    end

    // Scan from the most significant digit down; a digit is blanked while
    // it and everything above it are zero. Digit 0 always stays lit.
    always_comb begin
        supp       = '0;
        zero_above = 1'b1;
        for (int unsigned k = NUM_DIGITS; k > 0; k--) begin
            zero_above = zero_above & (lat_digits_q[k-1] == 4'd0);
            if (k > 1) begin
                supp[k-1] = lat_lz_q & zero_above;
            end
        end
    end

    always_comb begin
        seg_d      = SEG_OFF;
        dp_n_d     = 1'b1;
        an_n_d     = '1;
        scan_idx_d = idx_q;
        if (en && !blank_set && !supp[idx_q]) begin
            an_n_d[idx_q] = 1'b0;
            if (!(blink_phase_q && lat_blink_q[idx_q])) begin
                seg_d  = glyph;
                dp_n_d = ~lat_dp_q[idx_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q         <= '0;
            idx_q         <= '0;
            frm_q         <= '0;
            blink_phase_q <= 1'b0;
            lat_digits_q  <= '0;
            lat_blink_q   <= '0;
            lat_dp_q      <= '0;
            lat_lz_q      <= 1'b0;
            seg_q         <= SEG_OFF;
            dp_n_q        <= 1'b1;
            an_n_q        <= '1;
            scan_idx_q    <= '0;
        end else begin
            pre_q         <= pre_d;
            idx_q         <= idx_d;
            frm_q         <= frm_d;
            blink_phase_q <= blink_phase_d;
            lat_digits_q  <= lat_digits_d;
            lat_blink_q   <= lat_blink_d;
            lat_dp_q      <= lat_dp_d;
            lat_lz_q      <= lat_lz_d;
            seg_q         <= seg_d;
            dp_n_q        <= dp_n_d;
            an_n_q        <= an_n_d;
            scan_idx_q    <= scan_idx_d;
        end
    end

    assign seg      = seg_q;
    assign dp_n     = dp_n_q;
    assign an_n     = an_n_q;
    assign scan_idx = scan_idx_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: expectations are queued per clock edge
// (counted from reset release) and a monitor compares them as cycles arrive.
module tb_seg_scan_driver;

    localparam logic [0:6] OFF = 7'b1111111;
    localparam logic [0:6] G0  = 7'b0000001;
    localparam logic [0:6] G1  = 7'b1001111;
    localparam logic [0:6] G2  = 7'b0010010;
    localparam logic [0:6] G3  = 7'b0000110;
    localparam logic [0:6] G4  = 7'b1001100;
    localparam logic [0:6] GA  = 7'b0001000;

    typedef struct packed {
        int         n;
        logic [3:0] an;
        logic [0:6] seg;
        logic       dpn;
        logic [1:0] idx;
        logic       chk_leg;
        logic [0:6] leg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] digits;
    logic        en;
    logic        blank_set;
    logic        lz_suppress;
    logic [3:0]  blink_mask;
    logic [3:0]  dp;

    logic [0:6]  seg;
    logic        dp_n;
    logic [3:0]  an_n;
    logic [1:0]  scan_idx;
    logic [0:6]  leg_seg;
    logic        leg_dp_n;
    logic [3:0]  leg_an_n;
    logic [1:0]  leg_idx;

    int   n_edge   = 0;
    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    string name_q[$];
    exp_t  cur;
    string cur_nm;

    always #5 clk = ~clk;

    seg_scan_driver #(
        .NUM_DIGITS   (4),
        .SCAN_DIV     (4),
        .BLINK_FRAMES (2),
        .HEX_MODE     (1)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .digits      (digits),
        .en          (en),
        .blank_set   (blank_set),
        .lz_suppress (lz_suppress),
        .blink_mask  (blink_mask),
        .dp          (dp),
        .seg         (seg),
        .dp_n        (dp_n),
        .an_n        (an_n),
        .scan_idx    (scan_idx)
    );

    seg_scan_driver #(
        .NUM_DIGITS   (4),
        .SCAN_DIV     (4),
        .BLINK_FRAMES (2),
        .HEX_MODE     (0)
    ) u_legacy (
        .clk         (clk),
        .rst_n       (rst_n),
        .digits      (digits),
        .en          (en),
        .blank_set   (blank_set),
        .lz_suppress (lz_suppress),
        .blink_mask  (blink_mask),
        .dp          (dp),
        .seg         (leg_seg),
        .dp_n        (leg_dp_n),
        .an_n        (leg_an_n),
        .scan_idx    (leg_idx)
    );

    always @(posedge clk) n_edge <= rst_n ? n_edge + 1 : 0;

    task automatic push(input int n, input logic [3:0] an, input logic [0:6] sg,
                        input logic dpn, input logic [1:0] ix, input string nm,
                        input logic chk_leg, input logic [0:6] lg);
        exp_t e;
        e.n = n; e.an = an; e.seg = sg; e.dpn = dpn; e.idx = ix;
        e.chk_leg = chk_leg; e.leg = lg;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // One slot = 4 edges; frame f, slot j covers edges 16f+4j+1 .. 16f+4j+4.
    task automatic push_slot(input int f, input int j, input logic [3:0] an,
                             input logic [0:6] sg, input logic dpn, input string nm,
                             input logic chk_leg, input logic [0:6] lg);
        for (int e = 1; e <= 4; e++) begin
            push(16*f + 4*j + e, an, sg, dpn, 2'(j), nm, chk_leg, lg);
        end
    endtask

    task automatic goto(input int n);
        while (n_edge < n) @(negedge clk);
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
    endtask

    always @(negedge clk) begin
        #1;
        while (exp_q.size() > 0 && exp_q[0].n <= n_edge) begin
            cur    = exp_q.pop_front();
            cur_nm = name_q.pop_front();
            checks++;
            if (cur.n < n_edge) begin
                failures++;
                $display("FAIL %s expectation for edge %0d not reached before edge %0d",
                         cur_nm, cur.n, n_edge);
            end else if (an_n !== cur.an || seg !== cur.seg || dp_n !== cur.dpn ||
                         scan_idx !== cur.idx) begin
                failures++;
                $display("FAIL %s @%0d got an_n=%b seg=%b dp_n=%b idx=%0d exp an_n=%b seg=%b dp_n=%b idx=%0d",
                         cur_nm, cur.n, an_n, seg, dp_n, scan_idx, cur.an, cur.seg, cur.dpn, cur.idx);
            end
            if (cur.chk_leg) begin
                checks++;
                if (leg_an_n !== cur.an || leg_seg !== cur.leg || leg_dp_n !== cur.dpn ||
                    leg_idx !== cur.idx) begin
                    failures++;
                    $display("FAIL %s_legacy @%0d got an_n=%b seg=%b dp_n=%b idx=%0d exp an_n=%b seg=%b dp_n=%b idx=%0d",
                             cur_nm, cur.n, leg_an_n, leg_seg, leg_dp_n, leg_idx,
                             cur.an, cur.leg, cur.dpn, cur.idx);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:6] f1_seg [4];
        logic [3:0] one;
        logic [3:0] an_j;
        one = 4'b0001;
        f1_seg[0] = G4; f1_seg[1] = G3; f1_seg[2] = G2; f1_seg[3] = G1;

        rst_n = 1'b0; en = 1'b1; blank_set = 1'b0; lz_suppress = 1'b0;
        blink_mask = 4'b0000; dp = 4'b0010; digits = 16'h1234;
        push(0, 4'b1111, OFF, 1'b1, 2'd0, "reset", 1'b0, OFF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        push(0, 4'b1111, OFF, 1'b1, 2'd0, "post_release", 1'b0, OFF);

        // Frame 0: latched zeros, no suppression, every digit shows "0".
        for (int j = 0; j < 4; j++) begin
            an_j = ~(one << j);
            push_slot(0, j, an_j, G0, 1'b1, "frame0_zeros", 1'b0, OFF);
        end
        // Frame 1: 1234 with decimal point on digit 1.
        for (int j = 0; j < 4; j++) begin
            an_j = ~(one << j);
            push_slot(1, j, an_j, f1_seg[j], (j == 1) ? 1'b0 : 1'b1, "frame1_scan", 1'b0, OFF);
        end
        // Frame 2: 0040 with suppression.
        push_slot(2, 0, 4'b1110, G0,  1'b1, "lz_0040_d0", 1'b0, OFF);
        push_slot(2, 1, 4'b1101, G4,  1'b1, "lz_0040_d1", 1'b0, OFF);
        push_slot(2, 2, 4'b1111, OFF, 1'b1, "lz_0040_d2", 1'b0, OFF);
        push_slot(2, 3, 4'b1111, OFF, 1'b1, "lz_0040_d3", 1'b0, OFF);
        // Frame 3: 0000 with suppression, only digit 0 lit.
        push_slot(3, 0, 4'b1110, G0, 1'b1, "lz_0000_d0", 1'b0, OFF);
        for (int j = 1; j < 4; j++) begin
            push_slot(3, j, 4'b1111, OFF, 1'b1, "lz_0000_off", 1'b0, OFF);
        end
        // Frame 4: 000A hex vs legacy, blink phase 0.
        push_slot(4, 0, 4'b1110, GA, 1'b1, "hex_A", 1'b1, G0);
        for (int j = 1; j < 4; j++) begin
            an_j = ~(one << j);
            push_slot(4, j, an_j, G0, 1'b1, "hex_frame_zero", 1'b0, OFF);
        end
        // Frames 5..9, digit 0 only: shown, blanked 2 frames, shown again.
        push_slot(5, 0, 4'b1110, GA,  1'b1, "blink_on_f5",  1'b0, OFF);
        push_slot(6, 0, 4'b1110, OFF, 1'b1, "blink_off_f6", 1'b0, OFF);
        push_slot(7, 0, 4'b1110, OFF, 1'b1, "blink_off_f7", 1'b0, OFF);
        push_slot(8, 0, 4'b1110, GA,  1'b1, "blink_on_f8",  1'b0, OFF);
        push_slot(9, 0, 4'b1110, GA,  1'b1, "blink_on_f9",  1'b0, OFF);
        // Frame 10: blank_set and en forcing off mid-frame.
        push(165, 4'b1101, G0,  1'b1, 2'd1, "pre_blank",   1'b0, OFF);
        push(166, 4'b1111, OFF, 1'b1, 2'd1, "blank_set",   1'b0, OFF);
        push(167, 4'b1111, OFF, 1'b1, 2'd1, "blank_set",   1'b0, OFF);
        push(168, 4'b1111, OFF, 1'b1, 2'd1, "blank_set",   1'b0, OFF);
        push(169, 4'b1011, G0,  1'b1, 2'd2, "blank_clear", 1'b0, OFF);
        push(170, 4'b1011, G0,  1'b1, 2'd2, "blank_clear", 1'b0, OFF);
        push(171, 4'b1111, OFF, 1'b1, 2'd2, "en_low",      1'b0, OFF);
        push(172, 4'b1111, OFF, 1'b1, 2'd2, "en_low",      1'b0, OFF);
        push(173, 4'b0111, G0,  1'b1, 2'd3, "en_high",     1'b0, OFF);

        goto(20);
        digits = 16'h0040; lz_suppress = 1'b1; dp = 4'b0000;
        goto(40);
        digits = 16'h0000;
        goto(56);
        digits = 16'h000A; lz_suppress = 1'b0; blink_mask = 4'b0001;
        goto(165);
        blank_set = 1'b1;
        goto(168);
        blank_set = 1'b0;
        goto(170);
        en = 1'b0;
        goto(172);
        en = 1'b1;
        drain();

        // Reset in the middle of digit 1's slot; latches must clear too.
        goto(182);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        push(0, 4'b1111, OFF, 1'b1, 2'd0, "midrst_hold", 1'b0, OFF);
        @(negedge clk);
        rst_n = 1'b1;
        push(0, 4'b1111, OFF, 1'b1, 2'd0, "midrst_release", 1'b0, OFF);
        push_slot(0, 0, 4'b1110, G0, 1'b1, "midrst_idx0", 1'b0, OFF);
        push(5, 4'b1101, G0, 1'b1, 2'd1, "midrst_idx1", 1'b0, OFF);
        drain();

        while (exp_q.size() != 0) begin
            cur    = exp_q.pop_front();
            cur_nm = name_q.pop_front();
            checks++;
            failures++;
            $display("FAIL %s expectation for edge %0d never compared (now %0d)",
                     cur_nm, cur.n, n_edge);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
